// File: rtl/optical_tx_if.sv
// Word-source handshake and line-side status for the optical transmitter.
interface optical_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic                  din_ready;
  logic                  dout;
  logic                  busy;
  logic                  done;

  modport master (output din, din_valid, input din_ready, dout, busy, done);
  modport slave  (input din, din_valid, output din_ready, dout, busy, done);
endinterface

// File: rtl/optical_tx.sv
// Manchester serialiser for the optical link: preamble, MSB-first payload, idle-low gap.
// state    | meaning
// IDLE     | line low, waiting for a word
// PREAMBLE | sending alternating 1,0,... sync bits
// DATA     | sending payload bits MSB-first from shreg
// GAP      | line held low for the inter-frame gap
module optical_tx #(
  parameter int HALF_PERIOD   = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int PREAMBLE_BITS = 8,
  parameter int GAP_BITS      = 2
) (
  input logic         clk,
  input logic         rst,
  optical_tx_if.slave bus
);

  localparam int HCW   = $clog2(HALF_PERIOD) + 1;
  localparam int BMAX0 = (PREAMBLE_BITS > DATA_WIDTH) ? PREAMBLE_BITS : DATA_WIDTH;
  localparam int BMAX  = (BMAX0 > GAP_BITS) ? BMAX0 : GAP_BITS;
  localparam int BCW   = $clog2(BMAX) + 1;

  localparam logic [HCW-1:0] HALF_LAST = HCW'(HALF_PERIOD - 1);
  localparam logic [BCW-1:0] PRE_LAST  = BCW'(PREAMBLE_BITS - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0] GAP_LAST  = BCW'(GAP_BITS - 1);

  if (HALF_PERIOD < 1) begin : g_chk_half
    $error("optical_tx: HALF_PERIOD must be >= 1");
  end
  if (DATA_WIDTH < 1) begin : g_chk_data
    $error("optical_tx: DATA_WIDTH must be >= 1");
  end
  if (GAP_BITS < 1) begin : g_chk_gap
    $error("optical_tx: GAP_BITS must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, GAP} state_t;

  state_t                state, state_d;
  logic [HCW-1:0]        half_cnt, half_cnt_d;
  logic                  phase, phase_d;
  logic [BCW-1:0]        bit_cnt, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg, shreg_d;
  logic                  dout_d, done_d, tx_bit;
  logic                  half_end, bit_end, accept;

  assign bus.din_ready = (state == IDLE) && !rst;
  assign accept        = bus.din_valid && bus.din_ready;
  assign half_end      = (half_cnt == HALF_LAST);
  assign bit_end       = phase && half_end;

  always_comb begin
    state_d    = state;
    half_cnt_d = half_cnt;
    phase_d    = phase;
    bit_cnt_d  = bit_cnt;
    shreg_d    = shreg;
    done_d     = 1'b0;
    tx_bit     = 1'b0;
    dout_d     = 1'b0;

    if (state != IDLE) begin
      half_cnt_d = half_end ? '0 : half_cnt + 1'b1;
      phase_d    = phase ^ half_end;
    end

    unique case (state)
      IDLE: begin
        if (accept) begin
          shreg_d    = bus.din;
          half_cnt_d = '0;
          phase_d    = 1'b0;
          bit_cnt_d  = '0;
          state_d    = (PREAMBLE_BITS > 0) ? PREAMBLE : DATA;
        end
      end
      PREAMBLE: begin
        if (bit_end) begin
          if (bit_cnt == PRE_LAST) begin
            bit_cnt_d = '0;
            state_d   = DATA;
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = shreg << 1;
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = GAP;
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end
      GAP: begin
        if (bit_end) begin
          if (bit_cnt == GAP_LAST) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // dout is registered, so encode the symbol half that the next cycle presents
    unique case (state_d)
      PREAMBLE: tx_bit = ~bit_cnt_d[0];
      DATA:     tx_bit = shreg_d[DATA_WIDTH-1];
      default:  tx_bit = 1'b0;
    endcase
    if ((state_d == PREAMBLE) || (state_d == DATA)) begin
      dout_d = tx_bit ^ phase_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      half_cnt <= '0;
      phase    <= 1'b0;
      bit_cnt  <= '0;
      shreg    <= '0;
      bus.dout <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state    <= state_d;
      half_cnt <= half_cnt_d;
      phase    <= phase_d;
      bit_cnt  <= bit_cnt_d;
      shreg    <= shreg_d;
      bus.dout <= dout_d;
      bus.busy <= (state_d != IDLE);
      bus.done <= done_d;
    end
  end

endmodule

// File: tb/tb_optical_tx.sv
// Bench for optical_tx: one instance with preamble, one fast instance without, plus a loopback decoder.
module tb_optical_tx;

  localparam int DW    = 8;
  localparam int HPA   = 4;
  localparam int PA    = 4;
  localparam int GA    = 2;
  localparam int HPB   = 1;
  localparam int PB    = 0;
  localparam int GB    = 2;
  localparam int LEN_A = (PA + DW + GA) * 2 * HPA;
  localparam int LEN_B = (PB + DW + GB) * 2 * HPB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  optical_tx_if #(.DATA_WIDTH(DW)) bus_a ();
  optical_tx_if #(.DATA_WIDTH(DW)) bus_b ();

  optical_tx #(.HALF_PERIOD(HPA), .DATA_WIDTH(DW), .PREAMBLE_BITS(PA), .GAP_BITS(GA))
    dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  optical_tx #(.HALF_PERIOD(HPB), .DATA_WIDTH(DW), .PREAMBLE_BITS(PB), .GAP_BITS(GB))
    dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  typedef struct {
    logic [7:0]  din;
    logic [23:0] halves;
    bit          disturb;
  } vec_t;

  int   n_pass  = 0;
  int   n_total = 0;
  logic exp_q[$];
  logic cap[$];
  logic tx_sb[$];
  logic rx_q[$];
  int   rx_noedge = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // reference line waveform, one entry per clock
  task automatic push_symbol(input logic b, input int hp);
    for (int i = 0; i < hp; i++) exp_q.push_back(b);
    for (int i = 0; i < hp; i++) exp_q.push_back(!b);
  endtask

  task automatic build_model(input logic [7:0] w, input int hp, input int pb, input int gb);
    exp_q.delete();
    for (int k = 0; k < pb; k++) push_symbol((k % 2) == 0, hp);
    for (int i = DW - 1; i >= 0; i--) push_symbol(w[i], hp);
    for (int c = 0; c < gb * 2 * hp; c++) exp_q.push_back(1'b0);
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_len"}, cap.size(), exp_q.size());
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      check({tag, "_dout"}, cap[i], exp_q[i]);
  endtask

  task automatic check_table(input logic [23:0] halves, input int nh, input int hp, input string tag);
    for (int h = 0; h < nh; h++)
      for (int c = 0; c < hp; c++)
        check(tag, cap[h * hp + c], halves[nh - 1 - h]);
    for (int i = nh * hp; i < cap.size(); i++) check({tag, "_gap"}, cap[i], 1'b0);
  endtask

  // caller has driven din=w, din_valid=1 at a negedge while the DUT is idle
  task automatic frame_a(input logic [7:0] w, input bit keep_valid, input bit disturb);
    check("a_accept_ready", bus_a.din_ready, 1'b1);
    @(posedge clk);
    cap.delete();
    for (int c = 1; c <= LEN_A; c++) begin
      @(negedge clk);
      cap.push_back(bus_a.dout);
      check("a_busy", bus_a.busy, 1'b1);
      check("a_done_early", bus_a.done, 1'b0);
      check("a_ready_busy", bus_a.din_ready, 1'b0);
      if (c == 1 && !keep_valid) bus_a.din_valid = 1'b0;
      if (disturb && c == 30) begin
        bus_a.din       = ~w;
        bus_a.din_valid = 1'b1;
      end
      if (disturb && c == 31) bus_a.din_valid = 1'b0;
    end
    @(negedge clk);
    check("a_done", bus_a.done, 1'b1);
    check("a_done_busy", bus_a.busy, 1'b0);
    check("a_done_dout", bus_a.dout, 1'b0);
    check("a_done_ready", bus_a.din_ready, 1'b1);
    build_model(w, HPA, PA, GA);
    compare_model("a_model");
  endtask

  task automatic frame_b(input logic [7:0] w);
    bus_b.din       = w;
    bus_b.din_valid = 1'b1;
    for (int i = DW - 1; i >= 0; i--) tx_sb.push_back(w[i]);
    check("b_accept_ready", bus_b.din_ready, 1'b1);
    @(posedge clk);
    cap.delete();
    for (int c = 1; c <= LEN_B; c++) begin
      @(negedge clk);
      cap.push_back(bus_b.dout);
      check("b_busy", bus_b.busy, 1'b1);
      check("b_done_early", bus_b.done, 1'b0);
      if (c == 1) bus_b.din_valid = 1'b0;
    end
    @(negedge clk);
    check("b_done", bus_b.done, 1'b1);
    check("b_done_busy", bus_b.busy, 1'b0);
    build_model(w, HPB, PB, GB);
    compare_model("b_model");
  endtask

  task automatic idle_a(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_busy"}, bus_a.busy, 1'b0);
      check({tag, "_done"}, bus_a.done, 1'b0);
      check({tag, "_dout"}, bus_a.dout, 1'b0);
    end
  endtask

  function automatic int mid_edges(input bit rising);
    int n = 0;
    for (int i = 0; i < DW; i++) begin
      int m = PA * 2 * HPA + i * 2 * HPA + HPA;
      if (rising  && cap[m - 1] == 1'b0 && cap[m] == 1'b1) n++;
      if (!rising && cap[m - 1] == 1'b1 && cap[m] == 1'b0) n++;
    end
    return n;
  endfunction

  // loopback receiver: decode each bit from the direction of its mid-bit edge
  initial begin
    int   k = 0;
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_b.busy) begin
        if (k < DW * 2 * HPB && (k % (2 * HPB)) == HPB) begin
          rx_q.push_back(prev && !bus_b.dout);
          if (prev == bus_b.dout) rx_noedge++;
        end
        k++;
      end else begin
        k = 0;
      end
      prev = bus_b.dout;
    end
  end

  initial begin
    vec_t tbl[4];
    logic [7:0] w;
    tbl[0] = '{din: 8'hA5, halves: {8'h99, 16'h9966}, disturb: 1'b1};
    tbl[1] = '{din: 8'h00, halves: {8'h99, 16'h5555}, disturb: 1'b0};
    tbl[2] = '{din: 8'hFF, halves: {8'h99, 16'hAAAA}, disturb: 1'b0};
    tbl[3] = '{din: 8'h3C, halves: {8'h99, 16'h5AA5}, disturb: 1'b1};

    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.din = '0;
    bus_a.din_valid = 1'b0;
    bus_b.din = '0;
    bus_b.din_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("rst_dout", bus_a.dout, 1'b0);
      check("rst_busy", bus_a.busy, 1'b0);
      check("rst_ready", bus_a.din_ready, 1'b1);
      check("rst_done", bus_a.done, 1'b0);
    end

    // table frames, single-cycle valid; some rows disturb din/valid mid-frame
    for (int r = 0; r < 4; r++) begin
      bus_a.din       = tbl[r].din;
      bus_a.din_valid = 1'b1;
      frame_a(tbl[r].din, 1'b0, tbl[r].disturb);
      check_table(tbl[r].halves, 24, HPA, "tbl_dout");
      idle_a(4, "tbl_noqueue");
    end

    // back-to-back with din_valid held
    bus_a.din       = 8'h00;
    bus_a.din_valid = 1'b1;
    frame_a(8'h00, 1'b1, 1'b0);
    check("b2b_rise_edges", mid_edges(1'b1), 8);
    bus_a.din = 8'hFF;
    frame_a(8'hFF, 1'b1, 1'b0);
    check("b2b_fall_edges", mid_edges(1'b0), 8);
    bus_a.din_valid = 1'b0;
    idle_a(3, "b2b_end");

    // reset mid-frame
    bus_a.din       = 8'h3C;
    bus_a.din_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) bus_a.din_valid = 1'b0;
    end
    rst_a = 1'b1;
    @(negedge clk);
    check("abort_dout", bus_a.dout, 1'b0);
    check("abort_busy", bus_a.busy, 1'b0);
    check("abort_done", bus_a.done, 1'b0);
    rst_a = 1'b0;
    #1;
    check("abort_ready", bus_a.din_ready, 1'b1);
    idle_a(5, "abort_idle");
    bus_a.din       = 8'h3C;
    bus_a.din_valid = 1'b1;
    frame_a(8'h3C, 1'b0, 1'b0);
    check_table(tbl[3].halves, 24, HPA, "abort_next");

    // random words against the model
    for (int r = 0; r < 6; r++) begin
      w = 8'($urandom_range(0, 255));
      bus_a.din       = w;
      bus_a.din_valid = 1'b1;
      frame_a(w, 1'b0, 1'b0);
      idle_a($urandom_range(0, 3), "rand_idle");
    end

    // fast instance without preamble: table row, loopback and random words
    frame_b(8'h81);
    check_table({8'h00, 16'h9556}, 16, HPB, "b_tbl_81");
    frame_b(8'h00);
    frame_b(8'hFF);
    frame_b(8'h5A);
    for (int r = 0; r < 4; r++) begin
      w = 8'($urandom_range(0, 255));
      frame_b(w);
      @(negedge clk);
    end
    @(negedge clk);
    check("loop_count", rx_q.size(), tx_sb.size());
    for (int i = 0; i < rx_q.size() && i < tx_sb.size(); i++)
      check("loop_bit", rx_q[i], tx_sb[i]);
    check("loop_noedge", rx_noedge, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
